// File: rtl/gpu_pkg.sv
// Shared core-wide definitions: core_state encodings and default PC width.
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } core_state_t;

  localparam int DEF_PC_W = 8;

endpackage

// File: rtl/divergence_checker.sv
// Flags any enabled lane whose next PC differs from the selected shared PC.
module divergence_checker
  import gpu_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int PC_W    = DEF_PC_W
) (
  input  logic [THREADS*PC_W-1:0] i_lane_pc,
  input  logic [THREADS-1:0]      i_mask,
  input  logic [PC_W-1:0]         i_sel_pc,
  output logic                    o_mismatch
);

  always_comb begin
    o_mismatch = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (i_mask[i] && (i_lane_pc[i*PC_W +: PC_W] != i_sel_pc))
        o_mismatch = 1'b1;
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core warp sequencer driving core_state, shared PC and fetch gating.
// Optional lane-divergence flag built when DIVERGENCE_CHECK_EN is defined.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int PC_W    = DEF_PC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              thread_count,
  input  logic                    instr_valid,
  input  logic                    decoded_ret,
  input  logic [THREADS-1:0]      lsu_busy,
  input  logic [THREADS*PC_W-1:0] next_pc,
  output logic [2:0]              core_state,
  output logic [PC_W-1:0]         current_pc,
  output logic                    fetch_req,
  output logic [THREADS-1:0]      thread_enable,
  output logic                    done,
  output logic                    diverged
);

  core_state_t          r_state;
  logic [PC_W-1:0]      r_pc;
  logic [THREADS-1:0]   r_en;
  logic                 r_done;
  logic [THREADS-1:0]   w_mask;
  logic [PC_W-1:0]      w_sel_pc;
  logic                 w_found;
  logic                 w_busy;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < THREADS; i++)
      w_mask[i] = (4'(i) < thread_count);
  end

  // Lowest enabled lane wins; lane 0 when no lane is enabled.
  always_comb begin
    w_sel_pc = next_pc[0 +: PC_W];
    w_found  = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (!w_found && r_en[i]) begin
        w_sel_pc = next_pc[i*PC_W +: PC_W];
        w_found  = 1'b1;
      end
    end
  end

  assign w_busy = |(lsu_busy & r_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_en    <= '0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_en    <= w_mask;
          end
        end
        FETCH:   if (instr_valid) r_state <= DECODE;
        DECODE:  r_state <= REQUEST;
        REQUEST: r_state <= WAIT;
        WAIT:    if (!w_busy) r_state <= EXECUTE;
        EXECUTE: r_state <= UPDATE;
        UPDATE: begin
          if (decoded_ret) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= FETCH;
            r_pc    <= w_sel_pc;
          end
        end
        DONE: begin
          if (!start) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_en    <= '0;
          end
        end
      endcase
    end
  end

`ifdef DIVERGENCE_CHECK_EN
  logic w_mismatch;
  logic r_div;

  divergence_checker #(
    .THREADS (THREADS),
    .PC_W    (PC_W)
  ) u_div (
    .i_lane_pc  (next_pc),
    .i_mask     (r_en),
    .i_sel_pc   (w_sel_pc),
    .o_mismatch (w_mismatch)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_div <= 1'b0;
    else if (r_state == IDLE && start)
      r_div <= 1'b0;
    else if (r_state == UPDATE && !decoded_ret && w_mismatch)
      r_div <= 1'b1;
  end

  assign diverged = r_div;
`else
  assign diverged = 1'b0;
`endif

  assign core_state    = r_state;
  assign current_pc    = r_pc;
  assign fetch_req     = (r_state == FETCH);
  assign thread_enable = r_en;
  assign done          = r_done;

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboard bench for core_scheduler: driver queues expectations, monitor checks.
module tb_core_scheduler;

  localparam logic [2:0] S_I = 3'b000, S_F = 3'b001, S_D = 3'b010, S_R = 3'b011;
  localparam logic [2:0] S_W = 3'b100, S_E = 3'b101, S_U = 3'b110, S_N = 3'b111;
`ifdef DIVERGENCE_CHECK_EN
  localparam bit DVEN = 1'b1;
`else
  localparam bit DVEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  thread_count;
  logic        instr_valid;
  logic        decoded_ret;
  logic [3:0]  lsu_busy;
  logic [31:0] next_pc;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        fetch_req;
  logic [3:0]  thread_enable;
  logic        done;
  logic        diverged;

  core_scheduler #(.THREADS(4), .PC_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .thread_count  (thread_count),
    .instr_valid   (instr_valid),
    .decoded_ret   (decoded_ret),
    .lsu_busy      (lsu_busy),
    .next_pc       (next_pc),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .fetch_req     (fetch_req),
    .thread_enable (thread_enable),
    .done          (done),
    .diverged      (diverged)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [7:0] pc;
    logic       fr;
    logic [3:0] en;
    logic       dn;
    logic       dv;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int step = 0;

  task automatic tick(input logic [2:0] st, input int pc, input logic [3:0] en,
                      input bit dn, input bit dv);
    exp_t e;
    e.st = st;
    e.pc = 8'(pc);
    e.fr = (st == S_F);
    e.en = en;
    e.dn = dn;
    e.dv = dv & DVEN;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (core_state !== S_I || current_pc !== 8'd0 || fetch_req !== 1'b0 ||
        thread_enable !== 4'd0 || done !== 1'b0 || diverged !== 1'b0) begin
      errors++;
      $display("FAIL %s: got st=%b pc=%0d fr=%b en=%b dn=%b dv=%b, want all zero",
               nm, core_state, current_pc, fetch_req, thread_enable, done, diverged);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        step++;
        checks++;
        if (core_state !== e.st || current_pc !== e.pc || fetch_req !== e.fr ||
            thread_enable !== e.en || done !== e.dn || diverged !== e.dv) begin
          errors++;
          $display("FAIL step%0d: got st=%b pc=%0d fr=%b en=%b dn=%b dv=%b want st=%b pc=%0d fr=%b en=%b dn=%b dv=%b",
                   step, core_state, current_pc, fetch_req, thread_enable, done, diverged,
                   e.st, e.pc, e.fr, e.en, e.dn, e.dv);
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    start = 1'b0;
    thread_count = 4'd0;
    instr_valid = 1'b0;
    decoded_ret = 1'b0;
    lsu_busy = 4'd0;
    next_pc = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    // basic instruction, 6-cycle path
    start = 1'b1; thread_count = 4'd4; instr_valid = 1'b1; next_pc = {4{8'd5}};
    tick(S_F, 0, 4'hF, 0, 0);
    tick(S_D, 0, 4'hF, 0, 0);
    tick(S_R, 0, 4'hF, 0, 0);
    tick(S_W, 0, 4'hF, 0, 0);
    tick(S_E, 0, 4'hF, 0, 0);
    tick(S_U, 0, 4'hF, 0, 0);
    tick(S_F, 5, 4'hF, 0, 0);

    // memory stall: WAIT held 3 cycles
    next_pc = {4{8'd6}};
    tick(S_D, 5, 4'hF, 0, 0);
    tick(S_R, 5, 4'hF, 0, 0);
    tick(S_W, 5, 4'hF, 0, 0);
    lsu_busy = 4'b0010;
    tick(S_W, 5, 4'hF, 0, 0);
    tick(S_W, 5, 4'hF, 0, 0);
    lsu_busy = 4'b0000;
    tick(S_E, 5, 4'hF, 0, 0);
    tick(S_U, 5, 4'hF, 0, 0);

    // fetch stall: FETCH held 5 cycles
    instr_valid = 1'b0;
    repeat (5) tick(S_F, 6, 4'hF, 0, 0);
    instr_valid = 1'b1;
    tick(S_D, 6, 4'hF, 0, 0);
    tick(S_R, 6, 4'hF, 0, 0);
    tick(S_W, 6, 4'hF, 0, 0);
    tick(S_E, 6, 4'hF, 0, 0);
    tick(S_U, 6, 4'hF, 0, 0);

    // RET and done handshake
    decoded_ret = 1'b1;
    tick(S_N, 6, 4'hF, 1, 0);
    tick(S_N, 6, 4'hF, 1, 0);
    start = 1'b0; decoded_ret = 1'b0;
    tick(S_I, 6, 4'h0, 0, 0);

    // disabled-lane busy ignored
    start = 1'b1; thread_count = 4'd1; lsu_busy = 4'b1000; next_pc = {4{8'd3}};
    tick(S_F, 0, 4'h1, 0, 0);
    tick(S_D, 0, 4'h1, 0, 0);
    tick(S_R, 0, 4'h1, 0, 0);
    tick(S_W, 0, 4'h1, 0, 0);
    tick(S_E, 0, 4'h1, 0, 0);
    tick(S_U, 0, 4'h1, 0, 0);
    tick(S_F, 3, 4'h1, 0, 0);
    tick(S_D, 3, 4'h1, 0, 0);
    tick(S_R, 3, 4'h1, 0, 0);
    lsu_busy = 4'b0001;
    tick(S_W, 3, 4'h1, 0, 0);

    // async reset mid-WAIT, seen before the next edge
    #2 reset = 1'b1;
    #1 check_idle("async_reset");
    @(negedge clk);
    reset = 1'b0; lsu_busy = 4'd0;

    // divergence: lane1 disagrees
    thread_count = 4'd4; next_pc = {8'd9, 8'd9, 8'd7, 8'd9};
    tick(S_F, 0, 4'hF, 0, 0);
    tick(S_D, 0, 4'hF, 0, 0);
    tick(S_R, 0, 4'hF, 0, 0);
    tick(S_W, 0, 4'hF, 0, 0);
    tick(S_E, 0, 4'hF, 0, 0);
    tick(S_U, 0, 4'hF, 0, 0);
    tick(S_F, 9, 4'hF, 0, 1);
    next_pc = {4{8'd9}};
    tick(S_D, 9, 4'hF, 0, 1);
    tick(S_R, 9, 4'hF, 0, 1);
    tick(S_W, 9, 4'hF, 0, 1);
    tick(S_E, 9, 4'hF, 0, 1);
    tick(S_U, 9, 4'hF, 0, 1);
    decoded_ret = 1'b1;
    tick(S_N, 9, 4'hF, 1, 1);
    start = 1'b0; decoded_ret = 1'b0;
    tick(S_I, 9, 4'h0, 0, 1);

    // thread_count=0: empty mask, busy ignored, lane 0 PC taken
    start = 1'b1; thread_count = 4'd0; lsu_busy = 4'hF;
    next_pc = {8'd1, 8'd2, 8'd3, 8'hFF};
    tick(S_F, 0, 4'h0, 0, 0);
    tick(S_D, 0, 4'h0, 0, 0);
    tick(S_R, 0, 4'h0, 0, 0);
    tick(S_W, 0, 4'h0, 0, 0);
    tick(S_E, 0, 4'h0, 0, 0);
    tick(S_U, 0, 4'h0, 0, 0);
    tick(S_F, 255, 4'h0, 0, 0);
    decoded_ret = 1'b1;
    tick(S_D, 255, 4'h0, 0, 0);
    tick(S_R, 255, 4'h0, 0, 0);
    tick(S_W, 255, 4'h0, 0, 0);
    tick(S_E, 255, 4'h0, 0, 0);
    tick(S_U, 255, 4'h0, 0, 0);
    start = 1'b0;
    tick(S_N, 255, 4'h0, 1, 0);
    decoded_ret = 1'b0;
    tick(S_I, 255, 4'h0, 0, 0);

    // thread_count above THREADS saturates the mask
    start = 1'b1; thread_count = 4'd12; lsu_busy = 4'd0;
    tick(S_F, 0, 4'hF, 0, 0);

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
